// File: rtl/morse_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the Morse message arbiter.
interface morse_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 enc_write_en;
  logic [7:0]           enc_ascii;
  logic                 enc_full;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 abort_pulse;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_last, enc_full,
    output req_ready, enc_write_en, enc_ascii, grant, busy, abort_pulse
  );

  // Requesters plus transmitter FIFO side
  modport master (
    output req_valid, req_data, req_last, enc_full,
    input  req_ready, enc_write_en, enc_ascii, grant, busy, abort_pulse
  );
endinterface

// File: rtl/morse_tx_arbiter.sv
// Round-robin message arbiter in front of a Morse transmitter write FIFO.
// One requester owns the port for a whole message; an optional separator
// follows every message end or timeout abort.
//
// state | meaning
// IDLE  | no owner, searching for the next requester after last_ptr
// XFER  | owner (last_ptr) streams characters, stall timer running
// SEP   | writing the separator character, held while the FIFO is full
module morse_tx_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter bit         INSERT_SEP = 1'b1,
  parameter logic [7:0] SEPARATOR  = 8'h20,
  parameter int         TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              arst,
  morse_tx_arbiter_if.slave bus
);

  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] STALL_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0] PTR_RESET  = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_SEP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        last_ptr_q, last_ptr_d;
  logic [CW-1:0]        stall_cnt_q, stall_cnt_d;
  logic                 abort_pulse_q, abort_pulse_d;

  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        cand_idx;
  int                   cand;

  logic                 owner_valid;
  logic                 owner_last;
  logic [7:0]           owner_data;
  logic                 xfer;
  logic                 stall_idle;
  logic                 timeout_hit;
  state_t               end_state;

  // In XFER the owner is always the last served requester.
  assign owner_valid = bus.req_valid[last_ptr_q];
  assign owner_last  = bus.req_last[last_ptr_q];
  assign owner_data  = bus.req_data[{last_ptr_q, 3'b000} +: 8];

  assign xfer        = (state_q == ST_XFER) && owner_valid && !bus.enc_full;
  assign stall_idle  = (state_q == ST_XFER) && !owner_valid;
  assign timeout_hit = (TIMEOUT != 0) && stall_idle && (stall_cnt_q == STALL_LAST);
  assign end_state   = INSERT_SEP ? ST_SEP : ST_IDLE;

  // Round-robin search: first valid index after last_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_ptr_q;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_ptr_q) + k) % NUM_REQ;
      cand_idx = PW'(cand);
      if (!pick_found && bus.req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Combinational write port and per-requester ready.
  always_comb begin
    bus.req_ready    = '0;
    bus.enc_write_en = 1'b0;
    bus.enc_ascii    = 8'h00;
    case (state_q)
      ST_XFER: begin
        bus.req_ready[last_ptr_q] = ~bus.enc_full;
        if (xfer) begin
          bus.enc_write_en = 1'b1;
          bus.enc_ascii    = owner_data;
        end
      end
      ST_SEP: begin
        if (!bus.enc_full) begin
          bus.enc_write_en = 1'b1;
          bus.enc_ascii    = SEPARATOR;
        end
      end
      default: ;
    endcase
  end

  // Next-state: grant on message boundaries, stall timer, abort.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_ptr_d    = last_ptr_q;
    stall_cnt_d   = stall_cnt_q;
    abort_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          last_ptr_d  = pick_idx;
          stall_cnt_d = '0;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer) begin
          stall_cnt_d = '0;
          if (owner_last) begin
            grant_d = '0;
            state_d = end_state;
          end
        end else if (stall_idle && (TIMEOUT != 0)) begin
          if (timeout_hit) begin
            abort_pulse_d = 1'b1;
            grant_d       = '0;
            stall_cnt_d   = '0;
            state_d       = end_state;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      ST_SEP: begin
        if (!bus.enc_full) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_ptr_q    <= PTR_RESET;
      stall_cnt_q   <= '0;
      abort_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_ptr_q    <= last_ptr_d;
      stall_cnt_q   <= stall_cnt_d;
      abort_pulse_q <= abort_pulse_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.abort_pulse = abort_pulse_q;

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// Bench for morse_tx_arbiter: two instances (separator on / off, TIMEOUT=4)
// fed the same requester scripts, checked cycle by cycle against a
// message-level model and by the characters that reach the FIFO.
module tb_morse_tx_arbiter;
  localparam int         N   = 4;
  localparam int         TMO = 4;
  localparam logic [7:0] SEP = 8'h20;

  typedef struct {
    logic [7:0] ch;
    bit         last;
    int         gap;
  } item_t;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  morse_tx_arbiter_if #(.NUM_REQ(N)) bus0 ();
  morse_tx_arbiter_if #(.NUM_REQ(N)) bus1 ();

  morse_tx_arbiter #(.NUM_REQ(N), .INSERT_SEP(1'b1), .SEPARATOR(SEP), .TIMEOUT(TMO))
    dut0 (.clk(clk), .arst(arst), .bus(bus0.slave));
  morse_tx_arbiter #(.NUM_REQ(N), .INSERT_SEP(1'b0), .SEPARATOR(SEP), .TIMEOUT(TMO))
    dut1 (.clk(clk), .arst(arst), .bus(bus1.slave));

  logic [N-1:0]   valid_s[2], last_s[2], ready_s[2], grant_s[2];
  logic [8*N-1:0] data_s[2];
  logic           full_s[2], we_s[2], busy_s[2], abort_s[2];
  logic [7:0]     ascii_s[2];

  assign bus0.req_valid = valid_s[0];
  assign bus0.req_data  = data_s[0];
  assign bus0.req_last  = last_s[0];
  assign bus0.enc_full  = full_s[0];
  assign bus1.req_valid = valid_s[1];
  assign bus1.req_data  = data_s[1];
  assign bus1.req_last  = last_s[1];
  assign bus1.enc_full  = full_s[1];
  assign ready_s[0] = bus0.req_ready;    assign ready_s[1] = bus1.req_ready;
  assign grant_s[0] = bus0.grant;        assign grant_s[1] = bus1.grant;
  assign we_s[0]    = bus0.enc_write_en; assign we_s[1]    = bus1.enc_write_en;
  assign ascii_s[0] = bus0.enc_ascii;    assign ascii_s[1] = bus1.enc_ascii;
  assign busy_s[0]  = bus0.busy;         assign busy_s[1]  = bus1.busy;
  assign abort_s[0] = bus0.abort_pulse;  assign abort_s[1] = bus1.abort_pulse;

  // requester scripts: per lane, per requester, characters with a valid-low gap
  item_t rq[2][N][$];
  int    wait_cnt[2][N];
  int    full_mode = 0;   // 0 off, 1 toggle, 2 rand 30%, 3 rand 70%, 4 held
  bit    rst_cmd   = 1'b1;
  int    cyc       = 0;

  // model: 0 = nobody owns the port, 1 = owner streaming, 2 = separator owed
  int   m_phase[2], m_owner[2], m_prev[2], m_idles[2];
  bit   m_abort_next[2];
  bit   m_sep[2];
  logic [7:0] log_q[2][$];
  int   aborts[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int prev);
    for (int k = 1; k <= N; k++)
      if (v[(prev + k) % N]) return (prev + k) % N;
    return 0;
  endfunction

  task automatic push_item(input int i, input logic [7:0] ch, input bit last, input int gap);
    item_t it;
    it.ch = ch; it.last = last; it.gap = gap;
    for (int l = 0; l < 2; l++) rq[l][i].push_back(it);
  endtask

  task automatic load_msg(input int i, input string s);
    for (int k = 0; k < s.len(); k++) push_item(i, s[k], k == s.len() - 1, 0);
  endtask

  task automatic model_reset(input int l);
    m_phase[l] = 0; m_owner[l] = 0; m_prev[l] = N - 1;
    m_idles[l] = 0; m_abort_next[l] = 1'b0;
  endtask

  task automatic drive();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < N; i++) begin
        valid_s[l][i] = 1'b0;
        last_s[l][i]  = 1'b0;
        data_s[l][8*i +: 8] = 8'h00;
        if (rq[l][i].size() > 0 && wait_cnt[l][i] >= rq[l][i][0].gap) begin
          valid_s[l][i] = 1'b1;
          last_s[l][i]  = rq[l][i][0].last;
          data_s[l][8*i +: 8] = rq[l][i][0].ch;
        end
      end
      case (full_mode)
        1:       full_s[l] = cyc[0];
        2:       full_s[l] = ($urandom_range(0, 99) < 30);
        3:       full_s[l] = ($urandom_range(0, 99) < 70);
        4:       full_s[l] = 1'b1;
        default: full_s[l] = 1'b0;
      endcase
    end
  endtask

  task automatic reset_check(input int l);
    string t;
    t = $sformatf("L%0d c%0d rst", l, cyc);
    chk({t, " grant"}, 32'(grant_s[l]), 0);
    chk({t, " busy"},  32'(busy_s[l]), 0);
    chk({t, " ready"}, 32'(ready_s[l]), 0);
    chk({t, " we"},    32'(we_s[l]), 0);
    chk({t, " ascii"}, 32'(ascii_s[l]), 0);
    chk({t, " abort"}, 32'(abort_s[l]), 0);
    model_reset(l);
  endtask

  task automatic model_step(input int l);
    logic [N-1:0] e_grant, e_ready;
    logic         e_we, e_busy, e_abort;
    logic [7:0]   e_asc;
    int           g;
    string        t;
    e_grant = '0; e_ready = '0; e_we = 1'b0; e_asc = 8'h00;
    e_busy  = (m_phase[l] != 0);
    e_abort = m_abort_next[l];
    m_abort_next[l] = 1'b0;
    g = m_owner[l];
    case (m_phase[l])
      0: if (|valid_s[l]) begin
        g = rr_pick(valid_s[l], m_prev[l]);
        m_owner[l] = g; m_prev[l] = g; m_idles[l] = 0; m_phase[l] = 1;
      end
      1: begin
        e_grant[g] = 1'b1;
        e_ready[g] = !full_s[l];
        if (valid_s[l][g] && !full_s[l]) begin
          e_we = 1'b1; e_asc = data_s[l][8*g +: 8]; m_idles[l] = 0;
          if (last_s[l][g]) m_phase[l] = m_sep[l] ? 2 : 0;
        end else if (!valid_s[l][g]) begin
          m_idles[l]++;
          if (m_idles[l] == TMO) begin
            m_abort_next[l] = 1'b1;
            m_phase[l] = m_sep[l] ? 2 : 0;
          end
        end
      end
      default: if (!full_s[l]) begin
        e_we = 1'b1; e_asc = SEP; m_phase[l] = 0;
      end
    endcase
    t = $sformatf("L%0d c%0d", l, cyc);
    chk({t, " grant"}, 32'(grant_s[l]), 32'(e_grant));
    chk({t, " ready"}, 32'(ready_s[l]), 32'(e_ready));
    chk({t, " we"},    32'(we_s[l]), 32'(e_we));
    chk({t, " ascii"}, 32'(ascii_s[l]), 32'(e_asc));
    chk({t, " busy"},  32'(busy_s[l]), 32'(e_busy));
    chk({t, " abort"}, 32'(abort_s[l]), 32'(e_abort));
    for (int i = 0; i < N; i++) begin
      if (valid_s[l][i] && e_ready[i]) begin
        void'(rq[l][i].pop_front());
        wait_cnt[l][i] = 0;
      end else if (rq[l][i].size() > 0 && !valid_s[l][i]) begin
        wait_cnt[l][i]++;
      end
    end
    if (we_s[l])    log_q[l].push_back(ascii_s[l]);
    if (abort_s[l]) aborts[l]++;
  endtask

  task automatic step();
    @(negedge clk);
    arst = rst_cmd;
    cyc++;
    drive();
    #1;
    for (int l = 0; l < 2; l++) begin
      if (arst) reset_check(l);
      else      model_step(l);
    end
  endtask

  function automatic bit all_done();
    for (int l = 0; l < 2; l++) begin
      if (m_phase[l] != 0) return 1'b0;
      for (int i = 0; i < N; i++) if (rq[l][i].size() > 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_drain(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (k < max_cyc && !all_done()) begin
      step();
      k++;
    end
    chk({tag, " drained"}, 32'(k < max_cyc), 1);
    step();
    step();
  endtask

  task automatic chk_log(input int l, input string exp, input string tag);
    chk($sformatf("%s L%0d len", tag, l), 32'(log_q[l].size()), 32'(exp.len()));
    for (int k = 0; k < exp.len() && k < log_q[l].size(); k++)
      chk($sformatf("%s L%0d ch%0d", tag, l, k), 32'(log_q[l][k]), 32'(exp[k]));
    log_q[l].delete();
  endtask

  initial begin
    int len;
    m_sep[0] = 1'b1;
    m_sep[1] = 1'b0;
    for (int l = 0; l < 2; l++) begin
      model_reset(l);
      aborts[l] = 0;
      for (int i = 0; i < N; i++) wait_cnt[l][i] = 0;
    end

    // reset with all requesters valid, then round robin of "ABC" x4
    for (int i = 0; i < N; i++) load_msg(i, "ABC");
    rst_cmd = 1'b1;
    step();
    step();
    rst_cmd = 1'b0;
    run_drain("rr", 200);
    chk_log(0, "ABC ABC ABC ABC ", "rr");
    chk_log(1, "ABCABCABCABC", "rr");

    // timeout: owner 0 sends H then stalls; requester 1 waits
    for (int l = 0; l < 2; l++) aborts[l] = 0;
    push_item(0, 8'h48, 1'b0, 0);
    push_item(0, 8'h49, 1'b1, 6);
    push_item(1, 8'h59, 1'b1, 0);
    run_drain("tmo", 200);
    chk_log(0, "H Y I ", "tmo");
    chk_log(1, "HYI", "tmo");
    chk("tmo aborts L0", 32'(aborts[0]), 1);
    chk("tmo aborts L1", 32'(aborts[1]), 1);

    // fairness: requester 2 re-asserts right after its last, 3 is waiting
    load_msg(2, "AB");
    load_msg(2, "CD");
    load_msg(3, "Z");
    run_drain("fair", 200);
    chk_log(0, "AB Z CD ", "fair");
    chk_log(1, "ABZCD", "fair");

    // backpressure: FIFO full every other cycle
    for (int l = 0; l < 2; l++) aborts[l] = 0;
    full_mode = 1;
    load_msg(1, "SOS");
    run_drain("bp", 200);
    full_mode = 0;
    chk_log(0, "SOS ", "bp");
    chk_log(1, "SOS", "bp");
    chk("bp aborts L0", 32'(aborts[0]), 0);
    chk("bp aborts L1", 32'(aborts[1]), 0);

    // FIFO full for 10 cycles right after a last character
    load_msg(0, "E");
    for (int k = 0; k < 20 && log_q[0].size() == 0; k++) step();
    chk("sepfull first write", 32'(log_q[0].size()), 1);
    full_mode = 4;
    for (int k = 0; k < 10; k++) step();
    chk("sepfull held writes", 32'(log_q[0].size()), 1);
    full_mode = 0;
    run_drain("sepfull", 50);
    chk_log(0, "E ", "sepfull");
    chk_log(1, "E", "sepfull");

    // random messages, random gaps (some long enough to abort), random full
    for (int i = 0; i < N; i++) begin
      for (int m = 0; m < 15; m++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++)
          push_item(i, 8'h41 + 8'($urandom_range(0, 25)), k == len - 1,
                    ($urandom_range(0, 99) < 6) ? $urandom_range(5, 7) : $urandom_range(0, 2));
      end
    end
    full_mode = 2;
    run_drain("rand30", 6000);
    for (int i = 0; i < N; i++) load_msg(i, "QRSTU");
    full_mode = 3;
    run_drain("rand70", 2000);
    full_mode = 0;
    for (int l = 0; l < 2; l++) log_q[l].delete();

    // reset in the middle of a message
    load_msg(0, "LONGMSG");
    for (int k = 0; k < 4; k++) step();
    rst_cmd = 1'b1;
    step();
    step();
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < N; i++) begin
        rq[l][i].delete();
        wait_cnt[l][i] = 0;
      end
    rst_cmd = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("midrst L0 grant", 32'(grant_s[0]), 0);
    chk("midrst L1 busy", 32'(busy_s[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/morse_tx_arbiter.md
# morse_tx_arbiter

Round-robin message arbiter sharing one Morse transmitter's ASCII write port among `NUM_REQ` independent requesters. Each requester streams a framed message (valid/ready/data/last). The arbiter grants one requester per message and forwards its characters into the transmitter's write FIFO, honouring `full`. Between messages it optionally inserts a separator character, and it reclaims the port from a requester that stalls mid-message.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `INSERT_SEP`, 1: 1 = write `SEPARATOR` after every message end or abort.
- `SEPARATOR`, 8'h20: ASCII separator character (word gap).
- `TIMEOUT`, 1000: idle-stall limit in clk cycles; 0 disables the timeout.

- `clk`  in  1  sole clock; the transmitter write-side clock.
- `arst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester character valid.
- `req_data`  in  8*NUM_REQ  requester i character at [8*i+7:8*i].
- `req_last`  in  NUM_REQ  qualifies `req_data` as last character of the message.
- `req_ready`  out  NUM_REQ  per-requester accept.
- `enc_write_en`  out  1  write strobe to transmitter FIFO.
- `enc_ascii`  out  8  character to transmitter FIFO.
- `enc_full`  in  1  transmitter FIFO full.
- `grant`  out  NUM_REQ  registered one-hot current owner; zero when none.
- `busy`  out  1  state != IDLE.
- `abort_pulse`  out  1  one-cycle pulse when a message is aborted by timeout.

## Operation
- States: IDLE, XFER, SEP. Registered: `state`, `grant`, `last_ptr` (index of last served requester), `stall_cnt` ($clog2(TIMEOUT+1) bits, min 1), `abort_pulse`.
- IDLE: if any `req_valid`, select the first asserted index searching `last_ptr+1, last_ptr+2, ...` modulo NUM_REQ. Register its one-hot into `grant` and go to XFER. Set `last_ptr` to that index. Clear `stall_cnt`.
- XFER, owner g: `req_ready[g] = ~enc_full`; all other `req_ready` bits are 0.
  - Transfer = `req_valid[g] & ~enc_full`. It drives `enc_write_en=1` and `enc_ascii=req_data[g]` combinationally in the same cycle.
  - Transfer with `req_last[g]`: clear `grant`; go to SEP if INSERT_SEP, else IDLE.
  - Transfer without last: clear `stall_cnt`.
  - Cycle with `req_valid[g]=0` (and TIMEOUT != 0): increment `stall_cnt`. Cycles stalled by `enc_full` with valid high do not count and do not clear.
  - `stall_cnt == TIMEOUT-1` on a non-transfer idle cycle: `abort_pulse`=1 next cycle; clear `grant`; go to SEP if INSERT_SEP, else IDLE. The requester's remaining characters form a new message on its next grant.
- SEP: `enc_write_en = ~enc_full`, `enc_ascii = SEPARATOR`. Once written, go to IDLE. Hold in SEP while full.
- `enc_ascii` = 8'h00 whenever `enc_write_en` = 0.
- `grant` changes only on message boundaries. A requester never loses the port mid-message except by timeout.

## Timing
- Reset (async assert, released synchronously to clk by the system): state IDLE, `grant`=0, `last_ptr`=NUM_REQ-1 (requester 0 wins first), `stall_cnt`=0, `abort_pulse`=0. Combinational outputs during reset: `req_ready`=0, `enc_write_en`=0, `enc_ascii`=0, `busy`=0.
- Request-to-first-write: valid seen in IDLE at cycle N; `grant` visible N+1; first write N+1 if not full.
- Throughput: 1 character per cycle within a message while not full.
- Message-to-message turnaround:
  - INSERT_SEP=1: last write N, separator N+1, IDLE N+2, next write N+3.
  - INSERT_SEP=0: next write N+2.
- Simultaneous events:
  - Transfer and timeout threshold in the same cycle: the transfer wins and the counter clears.
  - `req_last` with `enc_full`: no transfer; wait.
  - Valid dropped while full: counts as idle.
- Reset mid-message discards the grant and all state. No partial separator is written.

## Test plan
- Reset: assert `arst` with `req_valid`=4'b1111 → all outputs 0, `busy`=0. After release, `grant`=4'b0001 one cycle after the first IDLE sample.
- Round-robin: requesters 0,1,2,3 each hold a 3-char message ("ABC" with last on C), `enc_full`=0 → FIFO receives A,B,C,20,… in grant order 0,1,2,3. No interleaving. 5 cycles per message.
- Backpressure: owner sends "SOS" while `enc_full` toggles 1 every other cycle → exactly S,O,S,20 written. `req_ready` mirrors ~full. No duplicates or drops. No abort.
- Timeout (TIMEOUT=4): owner writes 'H' then drops valid → `abort_pulse` on the 5th cycle after 'H'. Separator 0x20 written. Requester 1 (valid) is granted next.
- Fairness with INSERT_SEP=0: requester 2 re-asserts immediately after its last, requester 3 waiting → requester 3 granted before 2. Turnaround is 2 cycles.
- Full during SEP: `enc_full`=1 for 10 cycles after a last → state stays SEP. Exactly one 0x20 is written after full drops. `busy` stays 1 throughout.
